// File: rtl/xadc_dual_channel_reader_if.sv
// Shared DRP address type and the AXI-Stream bundle
// used by the XADC dual-channel reader.
package xadc_pkg;
    typedef logic [6:0] xadc_drp_addr_t;
endpackage

// AXI-Stream bundle: tdata/tvalid from source, tready from sink.
interface axis_interface #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport Source (output tdata, output tvalid, input tready);
    modport Sink   (input tdata, input tvalid, output tready);
endinterface

// File: rtl/xadc_dual_channel_reader.sv
// Reads VAUX voltage and current results over the XADC DRP
// on each end-of-sequence and streams them as 12-bit samples.
module xadc_dual_channel_reader
    import xadc_pkg::*;
#(
    parameter int             XADC_DRP_DATA_WIDTH = 16,
    parameter xadc_drp_addr_t VOLTAGE_ADDR        = 7'h14,
    parameter xadc_drp_addr_t CURRENT_ADDR        = 7'h1C
) (
    input  logic                           xadc_dclk,
    input  logic                           xadc_reset,
    output xadc_drp_addr_t                 xadc_daddr,
    output logic                           xadc_den,
    input  logic                           xadc_drdy,
    input  logic [XADC_DRP_DATA_WIDTH-1:0] xadc_do,
    input  logic                           xadc_eos,
    axis_interface.Source                  voltage_channel,
    axis_interface.Source                  current_monitor_channel
);
    localparam int W = XADC_DRP_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        RD_VOLT,
        WAIT_VOLT,
        RD_CURR,
        WAIT_CURR
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           v_valid;
    logic           c_valid;
    logic [W-1:0]   v_data;
    logic [W-1:0]   c_data;
    logic           v_busy;
    logic           c_busy;
    logic [W-1:0]   sample;
    logic           unused_low;

    // XADC results are left-justified; the low nibble is noise bits.
    assign sample     = {{(W-12){1'b0}}, xadc_do[W-1:W-12]};
    assign unused_low = ^xadc_do[W-13:0];

    // A channel still counts as busy unless it is handshaking now.
    assign v_busy = v_valid && !voltage_channel.tready;
    assign c_busy = c_valid && !current_monitor_channel.tready;

    assign voltage_channel.tdata          = v_data;
    assign voltage_channel.tvalid         = v_valid;
    assign current_monitor_channel.tdata  = c_data;
    assign current_monitor_channel.tvalid = c_valid;

    // State register.
    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and DRP strobes; one read in flight at a time.
    always_comb begin
        state_nxt  = state;
        xadc_den   = 1'b0;
        xadc_daddr = '0;
        unique case (state)
            IDLE: begin
                if (xadc_eos && !v_busy && !c_busy) begin
                    state_nxt = RD_VOLT;
                end
            end
            RD_VOLT: begin
                xadc_den   = 1'b1;
                xadc_daddr = VOLTAGE_ADDR;
                state_nxt  = WAIT_VOLT;
            end
            WAIT_VOLT: begin
                xadc_daddr = VOLTAGE_ADDR;
                if (xadc_drdy) begin
                    state_nxt = RD_CURR;
                end
            end
            RD_CURR: begin
                xadc_den   = 1'b1;
                xadc_daddr = CURRENT_ADDR;
                state_nxt  = WAIT_CURR;
            end
            WAIT_CURR: begin
                xadc_daddr = CURRENT_ADDR;
                if (xadc_drdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Voltage stream register: load on drdy, clear on handshake.
    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            v_valid <= 1'b0;
            v_data  <= '0;
        end else if (state == WAIT_VOLT && xadc_drdy) begin
            v_valid <= 1'b1;
            v_data  <= sample;
        end else if (v_valid && voltage_channel.tready) begin
            v_valid <= 1'b0;
        end
    end

    // Current stream register: load on drdy, clear on handshake.
    always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
        if (xadc_reset) begin
            c_valid <= 1'b0;
            c_data  <= '0;
        end else if (state == WAIT_CURR && xadc_drdy) begin
            c_valid <= 1'b1;
            c_data  <= sample;
        end else if (c_valid && current_monitor_channel.tready) begin
            c_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xadc_dual_channel_reader.sv
// Directed bench for the XADC dual-channel reader with a
// DRP responder model and per-channel expected-sample queues.
module tb_xadc_dual_channel_reader;
    logic        clk;
    logic        rst;
    logic [6:0]  daddr;
    logic        den;
    logic        drdy;
    logic [15:0] do_bus;
    logic        eos;

    axis_interface #(.DATA_WIDTH(16)) vch ();
    axis_interface #(.DATA_WIDTH(16)) cch ();

    xadc_dual_channel_reader dut (
        .xadc_dclk               (clk),
        .xadc_reset              (rst),
        .xadc_daddr              (daddr),
        .xadc_den                (den),
        .xadc_drdy               (drdy),
        .xadc_do                 (do_bus),
        .xadc_eos                (eos),
        .voltage_channel         (vch.Source),
        .current_monitor_channel (cch.Source)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_v[$];
    logic [15:0] exp_c[$];
    logic [15:0] v_do_val;
    logic [15:0] c_do_val;
    int          drdy_delay;
    bit          abandon;
    logic [6:0]  bfm_addr;
    int          dens;
    bit          outstanding;
    logic [6:0]  nxt_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each handshake pops the oldest expected sample.
    always @(negedge clk) begin
        if (!rst) begin
            if (vch.tvalid && vch.tready) begin
                if (exp_v.size() == 0) check("v_extra", exp_v.size(), 1);
                else check("v_data", vch.tdata, exp_v.pop_front());
            end
            if (cch.tvalid && cch.tready) begin
                if (exp_c.size() == 0) check("c_extra", exp_c.size(), 1);
                else check("c_data", cch.tdata, exp_c.pop_front());
            end
        end
    end

    // DRP protocol monitor: single-cycle den, alternating address.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
            nxt_addr    = 7'h14;
        end else begin
            if (den) begin
                dens++;
                check("den_overlap", outstanding, 0);
                check("daddr", daddr, nxt_addr);
                outstanding = 1'b1;
                nxt_addr    = (nxt_addr == 7'h14) ? 7'h1C : 7'h14;
            end
            if (drdy) outstanding = 1'b0;
        end
    end

    // DRP responder: answers each den after drdy_delay extra cycles.
    initial begin
        drdy   = 1'b0;
        do_bus = 16'hA5A5;
        forever begin
            while (rst || !den) @(negedge clk);
            bfm_addr = daddr;
            @(posedge clk);
            repeat (drdy_delay) @(posedge clk);
            #1;
            drdy   = 1'b1;
            do_bus = (bfm_addr == 7'h14) ? v_do_val : c_do_val;
            @(negedge clk);
            check("pre_drdy_valid",
                  (bfm_addr == 7'h14) ? vch.tvalid : cch.tvalid, 0);
            @(posedge clk);
            #1;
            drdy   = 1'b0;
            do_bus = 16'hA5A5;
            @(negedge clk);
            check("post_drdy_valid",
                  (bfm_addr == 7'h14) ? vch.tvalid : cch.tvalid,
                  abandon ? 0 : 1);
            abandon = 1'b0;
        end
    end

    task automatic pulse_eos(input bit start);
        @(posedge clk);
        #1 eos = 1'b1;
        @(posedge clk);
        #1 eos = 1'b0;
        @(negedge clk);
        check("den_after_eos", den, start);
        if (start) check("daddr_first", daddr, 7'h14);
    endtask

    task automatic start_seq(input logic [15:0] vd, input logic [15:0] cd,
                             input int dly);
        v_do_val   = vd;
        c_do_val   = cd;
        drdy_delay = dly;
        exp_v.push_back({4'h0, vd[15:4]});
        exp_c.push_back({4'h0, cd[15:4]});
        pulse_eos(1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_v.size() != 0 || exp_c.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_v.size() + exp_c.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_den"}, den, 0);
        check({tag, "_daddr"}, daddr, 0);
        check({tag, "_vvalid"}, vch.tvalid, 0);
        check({tag, "_cvalid"}, cch.tvalid, 0);
        check({tag, "_vdata"}, vch.tdata, 0);
        check({tag, "_cdata"}, cch.tdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        eos        = 1'b0;
        vch.tready = 1'b1;
        cch.tready = 1'b1;
        abandon    = 1'b0;
        drdy_delay = 0;
        dens       = 0;
        v_do_val   = 16'h0;
        c_do_val   = 16'h0;
        #2;
        check_idle_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        start_seq(16'hFFF0, 16'hF7F0, 0);
        wait_done();

        for (int i = 0; i < 10; i++) begin
            start_seq(16'($urandom), 16'($urandom), (i % 3 == 2) ? 7 : i % 3);
            wait_done();
        end
        check("den_count", dens, 22);

        vch.tready = 1'b0;
        start_seq(16'hFFF0, 16'h1230, 1);
        for (int n = 0; n < 200 && exp_c.size() != 0; n++) @(negedge clk);
        check("stall_c_drain", exp_c.size(), 0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("stall_vvalid", vch.tvalid, 1);
            check("stall_vdata", vch.tdata, 16'h0FFF);
        end
        pulse_eos(1'b0);
        repeat (3) @(negedge clk);
        check("stall_no_den", dens, 24);
        @(posedge clk);
        #1 vch.tready = 1'b1;
        wait_done();
        start_seq(16'h8880, 16'h4440, 0);
        wait_done();

        start_seq(16'h000F, 16'h0F0F, 7);
        wait_done();

        v_do_val   = 16'hBEE0;
        c_do_val   = 16'hCAF0;
        drdy_delay = 7;
        pulse_eos(1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        abandon = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (14) @(negedge clk);
        check("stray_vvalid", vch.tvalid, 0);
        start_seq(16'h3210, 16'h7650, 1);
        wait_done();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/xadc_dual_channel_reader.md
# xadc_dual_channel_reader

Sequencer between the XADC hard macro's DRP port and the XADC packetizer. On every end-of-sequence pulse it reads the two auxiliary-channel conversion results over the DRP and presents each as a right-justified 12-bit sample on its own AXI-Stream source. One channel carries voltage and the other carries current-monitor data. Both channels are consumed by the packetizer, which COBS-frames voltage then current.

## Interface
- Parameters:
  - XADC_DRP_DATA_WIDTH, 16, width of DRP data and of both stream tdata buses.
  - VOLTAGE_ADDR, 7'h14, DRP address of the VAUX4 status register, which is the voltage channel.
  - CURRENT_ADDR, 7'h1C, DRP address of the VAUX12 status register, which is the current-monitor channel.
- Ports:
  - xadc_dclk  in  1  single clock for everything, the XADC DCLK.
  - xadc_reset  in  1  asynchronous, active-high reset.
  - xadc_daddr  out  7  DRP address (xadc_drp_addr_t).
  - xadc_den  out  1  DRP enable, single-cycle pulse.
  - xadc_drdy  in  1  DRP read-data-valid strobe.
  - xadc_do  in  16  DRP read data.
  - xadc_eos  in  1  XADC end-of-sequence pulse.
  - voltage_channel  axis_interface.Source  16  tdata/tvalid out, tready in.
  - current_monitor_channel  axis_interface.Source  16  tdata/tvalid out, tready in.

## Operation
- Sample format: XADC results are left-justified in DO[15:4].
  - tdata = {4'b0, xadc_do[15:4]}, so the range is 0x0000–0x0FFF.
  - DO[3:0] is discarded.
- State machine states: IDLE, RD_VOLT, WAIT_VOLT, RD_CURR, WAIT_CURR.
- IDLE:
  - xadc_eos=1 and both channels' tvalid=0 → RD_VOLT.
  - xadc_eos=1 while either tvalid=1 → stay IDLE; that sequence is skipped (the sample pair is dropped).
  - xadc_eos=0 → stay IDLE.
- RD_VOLT: xadc_den=1 for exactly this cycle, xadc_daddr=VOLTAGE_ADDR → WAIT_VOLT.
- WAIT_VOLT:
  - Hold xadc_daddr and wait for xadc_drdy, with no timeout.
  - On drdy: load voltage tdata from xadc_do, set voltage tvalid, → RD_CURR.
- RD_CURR: xadc_den=1 for one cycle, xadc_daddr=CURRENT_ADDR → WAIT_CURR.
- WAIT_CURR: on drdy, load current tdata, set current tvalid → IDLE.
- Stream rule, identical for both channels:
  - tvalid stays high and tdata stays stable until a cycle with tvalid && tready.
  - tvalid clears on that handshake edge.
  - The two channels handshake independently.
- xadc_eos asserted outside IDLE is ignored. It is not queued.
- xadc_drdy outside the WAIT states is ignored.
- Write enable is never used; this block only reads.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - state=IDLE, xadc_den=0, xadc_daddr=0;
  - both tvalid=0 and both tdata=0.
- Reset mid-transaction:
  - Any outstanding DRP read is abandoned, and a late drdy is ignored.
  - Pending unaccepted samples are lost.
- Latency, with eos sampled high at edge N:
  - den high in cycle N+1 (addr 0x14).
  - If drdy is sampled at edge M, voltage tvalid is high from cycle M+1.
  - Current den is high in cycle M+1 (addr 0x1C).
  - If current drdy is sampled at edge K, current tvalid is high from K+1.
- Minimum eos-to-both-valid time is 4 cycles when drdy returns the cycle after den.
- With tready held at 1, each tvalid lasts exactly one cycle.
- eos coinciding with the final handshake cycle counts as a new sequence start, because tvalid is evaluated as already cleared.
- Only one DRP transaction is in flight at any time.

## Test plan
- After reset, with the XADC BFM returning 0xFFF0 for VAUX4 and 0xF7F0 for VAUX12, both tready=1 and an eos pulse:
  - voltage tdata=0x0FFF, then current tdata=0x0F7F.
  - Each presents a single tvalid cycle.
  - Downstream the packetizer emits 05 0F FF 0F 7F 00.
- DRP protocol check across 10 sequences:
  - den is a 1-cycle pulse.
  - daddr is 0x14, then 0x1C.
  - Never a second den before drdy.
  - den first rises exactly 1 cycle after eos.
- Backpressure: voltage tready=0 for 20 cycles:
  - voltage tdata stays 0x0FFF and tvalid stays 1.
  - An eos arriving during the stall causes no den.
  - After release, the next eos starts a new read.
- DRP delays: drdy delayed 0, 1 and 7 cycles → data is captured only on drdy; tvalid rises exactly 1 cycle after.
- Reset asserted while in WAIT_VOLT:
  - Outputs clear immediately (asynchronously).
  - A later stray drdy produces no tvalid.
  - The next eos runs a normal sequence.
- DO low nibble 0xF with upper bits 0 (DO=0x000F) → tdata=0x0000, confirming truncation.
